// File: rtl/safe_pkg.sv
// Shared types and sizes for the safe-game codebreaker controller.
package safe_pkg;
  localparam int PEGS   = 4;
  localparam int PEG_W  = 2;
  localparam int CODE_W = PEGS * PEG_W;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    EVAL    = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } safe_state_t;
endpackage

// File: rtl/safe_digit_reg.sv
// Guess pack register: k-th accepted digit lands in peg k; counts digits up to PEGS.
module safe_digit_reg
  import safe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr,
  input  logic [PEG_W-1:0]  digit,
  output logic [CODE_W-1:0] guess,
  output logic [CNT_W-1:0]  digits_cnt
);

  logic full;
  assign full = (digits_cnt == CNT_W'(PEGS));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      guess      <= '0;
      digits_cnt <= '0;
    end else if (wr && !full) begin
      guess[{digits_cnt[1:0], 1'b0} +: PEG_W] <= digit;
      digits_cnt <= digits_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/safe_guess_ctrl.sv
// Codebreaker controller: digit entry, one-cycle evaluation, attempt counting, open/lockout.
//
// state   | meaning
// ENTRY   | collecting digits, waiting for a submit with all pegs entered
// EVAL    | guess held for the evaluator; feedback captured this cycle
// OPEN    | safe open; submit re-keys with the entered guess, relock keeps the secret
// LOCKOUT | too many misses; all inputs ignored until the lock counter runs out
module safe_guess_ctrl
  import safe_pkg::*;
#(
  parameter int          MAX_TRIES   = 8,
  parameter int          LOCK_CYCLES = 50,
  parameter logic [7:0]  SECRET_INIT = 8'hE4,
  localparam int         TRY_W       = $clog2(MAX_TRIES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              digit_valid,
  input  logic [1:0]        digit,
  input  logic              submit,
  input  logic              clear,
  input  logic              relock,
  input  logic [3:0]        c_in,
  input  logic [3:0]        m_in,
  output logic [7:0]        guess,
  output logic [7:0]        secret,
  output logic [2:0]        digits_cnt,
  output logic [TRY_W-1:0]  tries,
  output logic              fb_valid,
  output logic [3:0]        fb_correct,
  output logic [3:0]        fb_misplaced,
  output logic              unlocked,
  output logic              locked_out
);

  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);

  safe_state_t       state, state_nxt;
  logic [7:0]        secret_nxt;
  logic [TRY_W-1:0]  tries_nxt;
  logic [LCK_W-1:0]  lock_cnt, lock_nxt;
  logic              dig_clr, dig_wr, fb_load, full;

  assign full = (digits_cnt == 3'(PEGS));

  safe_digit_reg u_digit_reg (
    .clk        (clk),
    .reset      (reset),
    .clr        (dig_clr),
    .wr         (dig_wr),
    .digit      (digit),
    .guess      (guess),
    .digits_cnt (digits_cnt)
  );

  always_comb begin
    state_nxt  = state;
    secret_nxt = secret;
    tries_nxt  = tries;
    lock_nxt   = lock_cnt;
    dig_clr    = 1'b0;
    dig_wr     = 1'b0;
    fb_load    = 1'b0;
    unique case (state)
      ENTRY: begin
        if (clear)                dig_clr   = 1'b1;
        else if (submit && full)  state_nxt = EVAL;
        else                      dig_wr    = digit_valid;
      end
      EVAL: begin
        fb_load = 1'b1;
        if (c_in == 4'hF) begin
          state_nxt = OPEN;
          tries_nxt = '0;
        end else begin
          tries_nxt = tries + TRY_W'(1);
          if (tries == TRY_W'(MAX_TRIES - 1)) begin
            state_nxt = LOCKOUT;
            lock_nxt  = LCK_W'(LOCK_CYCLES);
          end else begin
            state_nxt = ENTRY;
            dig_clr   = 1'b1;
          end
        end
      end
      OPEN: begin
        // a complete re-key outranks relock; clear cancels a pending re-key
        if (submit && full && !clear) begin
          secret_nxt = guess;
          tries_nxt  = '0;
          dig_clr    = 1'b1;
          state_nxt  = ENTRY;
        end else if (relock) begin
          tries_nxt  = '0;
          dig_clr    = 1'b1;
          state_nxt  = ENTRY;
        end else if (clear) begin
          dig_clr = 1'b1;
        end else begin
          dig_wr = digit_valid;
        end
      end
      LOCKOUT: begin
        lock_nxt = lock_cnt - LCK_W'(1);
        if (lock_cnt == LCK_W'(1)) begin
          state_nxt = ENTRY;
          tries_nxt = '0;
          dig_clr   = 1'b1;
        end
      end
      default: state_nxt = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ENTRY;
      secret       <= SECRET_INIT;
      tries        <= '0;
      lock_cnt     <= '0;
      fb_valid     <= 1'b0;
      fb_correct   <= '0;
      fb_misplaced <= '0;
    end else begin
      state    <= state_nxt;
      secret   <= secret_nxt;
      tries    <= tries_nxt;
      lock_cnt <= lock_nxt;
      fb_valid <= fb_load;
      if (fb_load) begin
        fb_correct   <= c_in;
        fb_misplaced <= m_in;
      end
    end
  end

  assign unlocked   = (state == OPEN);
  assign locked_out = (state == LOCKOUT);

endmodule

// File: tb/tb_safe_guess_ctrl.sv
// Self-checking bench: golden evaluator, directed table, corner sequences, random vs reference model.
module tb_safe_guess_ctrl;
  localparam int TB_MAX  = 3;
  localparam int TB_LOCK = 5;
  localparam int TRY_W   = $clog2(TB_MAX + 1);

  logic clk = 1'b0;
  logic reset, digit_valid, submit, clear, relock;
  logic [1:0] digit;
  logic [3:0] c_in, m_in, fb_correct, fb_misplaced;
  logic [7:0] guess, secret;
  logic [2:0] digits_cnt;
  logic [TRY_W-1:0] tries;
  logic fb_valid, unlocked, locked_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  safe_guess_ctrl #(.MAX_TRIES(TB_MAX), .LOCK_CYCLES(TB_LOCK), .SECRET_INIT(8'hE4)) dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit), .submit(submit),
    .clear(clear), .relock(relock), .c_in(c_in), .m_in(m_in), .guess(guess), .secret(secret),
    .digits_cnt(digits_cnt), .tries(tries), .fb_valid(fb_valid), .fb_correct(fb_correct),
    .fb_misplaced(fb_misplaced), .unlocked(unlocked), .locked_out(locked_out)
  );

  // golden evaluator: returns {m, c}; misplaced pegs claim unmatched secret pegs in order
  function automatic logic [7:0] eval_fn(input logic [7:0] g, input logic [7:0] s);
    logic [3:0] c, m;
    bit used[4];
    c = '0; m = '0;
    for (int k = 0; k < 4; k++) begin
      c[k] = (g[2*k +: 2] == s[2*k +: 2]);
      used[k] = c[k];
    end
    for (int k = 0; k < 4; k++)
      if (!c[k])
        for (int j = 0; j < 4; j++)
          if (!m[k] && !used[j] && g[2*k +: 2] == s[2*j +: 2]) begin
            m[k] = 1'b1;
            used[j] = 1'b1;
          end
    return {m, c};
  endfunction

  assign {m_in, c_in} = eval_fn(guess, secret);

  // reference model: mode 0=entering 1=evaluating 2=open 3=locked
  int mq[$];
  int mmode, mtries, mrem;
  logic [7:0] msecret;
  logic mfbv;
  logic [3:0] mfbc, mfbm;

  function automatic logic [7:0] mguess();
    int v = 0;
    foreach (mq[k]) v += mq[k] << (2 * k);
    return 8'(v);
  endfunction

  task automatic model_update(input bit dv, input int d, input bit sub, input bit clr,
                              input bit rl, input bit rst);
    logic [7:0] r;
    if (rst) begin
      mq.delete(); mmode = 0; mtries = 0; mrem = 0; msecret = 8'hE4;
      mfbv = 0; mfbc = 0; mfbm = 0;
      return;
    end
    mfbv = 0;
    case (mmode)
      0, 2: begin
        if (mmode == 2 && !clr && sub && mq.size() == 4) begin
          msecret = mguess(); mq.delete(); mtries = 0; mmode = 0;
        end else if (mmode == 2 && rl) begin
          mq.delete(); mtries = 0; mmode = 0;
        end else if (clr) begin
          mq.delete();
        end else if (mmode == 0 && sub && mq.size() == 4) begin
          mmode = 1;
        end else if (dv && mq.size() < 4) begin
          mq.push_back(d);
        end
      end
      1: begin
        r = eval_fn(mguess(), msecret);
        mfbc = r[3:0]; mfbm = r[7:4]; mfbv = 1;
        if (r[3:0] == 4'hF) begin
          mmode = 2; mtries = 0;
        end else begin
          mtries++;
          if (mtries == TB_MAX) begin
            mmode = 3; mrem = TB_LOCK;
          end else begin
            mq.delete(); mmode = 0;
          end
        end
      end
      default: begin
        if (mrem == 1) begin
          mmode = 0; mtries = 0; mq.delete();
        end
        mrem--;
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m_guess", 32'(guess), 32'(mguess()));
    chk("m_secret", 32'(secret), 32'(msecret));
    chk("m_digits_cnt", 32'(digits_cnt), 32'(mq.size()));
    chk("m_tries", 32'(tries), 32'(mtries));
    chk("m_fb_valid", 32'(fb_valid), 32'(mfbv));
    chk("m_fb_correct", 32'(fb_correct), 32'(mfbc));
    chk("m_fb_misplaced", 32'(fb_misplaced), 32'(mfbm));
    chk("m_unlocked", 32'(unlocked), 32'(mmode == 2));
    chk("m_locked_out", 32'(locked_out), 32'(mmode == 3));
  endtask

  task automatic step(input bit dv, input logic [1:0] d, input bit sub, input bit clr,
                      input bit rl, input bit rst);
    digit_valid = dv; digit = d; submit = sub; clear = clr; relock = rl; reset = rst;
    @(posedge clk);
    model_update(dv, int'(d), sub, clr, rl, rst);
    #1;
    digit_valid = 0; submit = 0; clear = 0; relock = 0; reset = 0;
    chk_model();
  endtask

  task automatic enter4(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                        input logic [1:0] e);
    step(1, a, 0, 0, 0, 0); step(1, b, 0, 0, 0, 0);
    step(1, c, 0, 0, 0, 0); step(1, e, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit dv; logic [1:0] d; bit sub; bit clr; bit rl;
    logic [2:0] e_cnt; logic [7:0] e_guess; bit e_unl; bit e_lck;
    logic [1:0] e_tries; bit e_fbv; logic [3:0] e_fbc; logic [3:0] e_fbm;
  } vec_t;

  vec_t tbl[15];
  int n_lock;
  logic [1:0] rd;

  initial begin
    digit_valid = 0; digit = 0; submit = 0; clear = 0; relock = 0; reset = 1;

    //         dv d     sub clr rl  cnt guess  unl lck tries fbv fbc      fbm
    tbl[0]  = '{1, 2'd0, 0, 0, 0, 3'd1, 8'h00, 0, 0, 2'd0, 0, 4'h0,    4'h0};
    tbl[1]  = '{1, 2'd1, 0, 0, 0, 3'd2, 8'h04, 0, 0, 2'd0, 0, 4'h0,    4'h0};
    tbl[2]  = '{1, 2'd2, 0, 0, 0, 3'd3, 8'h24, 0, 0, 2'd0, 0, 4'h0,    4'h0};
    tbl[3]  = '{1, 2'd3, 0, 0, 0, 3'd4, 8'hE4, 0, 0, 2'd0, 0, 4'h0,    4'h0};
    tbl[4]  = '{0, 2'd0, 1, 0, 0, 3'd4, 8'hE4, 0, 0, 2'd0, 0, 4'h0,    4'h0};
    tbl[5]  = '{0, 2'd0, 0, 0, 0, 3'd4, 8'hE4, 1, 0, 2'd0, 1, 4'hF,    4'h0};
    tbl[6]  = '{0, 2'd0, 0, 0, 1, 3'd0, 8'h00, 0, 0, 2'd0, 0, 4'hF,    4'h0};
    tbl[7]  = '{1, 2'd1, 0, 0, 0, 3'd1, 8'h01, 0, 0, 2'd0, 0, 4'hF,    4'h0};
    tbl[8]  = '{1, 2'd0, 0, 0, 0, 3'd2, 8'h01, 0, 0, 2'd0, 0, 4'hF,    4'h0};
    tbl[9]  = '{1, 2'd2, 1, 0, 0, 3'd3, 8'h21, 0, 0, 2'd0, 0, 4'hF,    4'h0};
    tbl[10] = '{1, 2'd3, 0, 0, 0, 3'd4, 8'hE1, 0, 0, 2'd0, 0, 4'hF,    4'h0};
    tbl[11] = '{0, 2'd0, 1, 0, 0, 3'd4, 8'hE1, 0, 0, 2'd0, 0, 4'hF,    4'h0};
    tbl[12] = '{0, 2'd0, 0, 0, 0, 3'd0, 8'h00, 0, 0, 2'd1, 1, 4'b1100, 4'b0011};
    tbl[13] = '{1, 2'd2, 0, 0, 0, 3'd1, 8'h02, 0, 0, 2'd1, 0, 4'b1100, 4'b0011};
    tbl[14] = '{1, 2'd3, 0, 1, 0, 3'd0, 8'h00, 0, 0, 2'd1, 0, 4'b1100, 4'b0011};

    step(0, 0, 0, 0, 0, 1);
    chk("rst_guess", 32'(guess), 32'h00);
    chk("rst_secret", 32'(secret), 32'hE4);
    chk("rst_fb_valid", 32'(fb_valid), 32'd0);

    foreach (tbl[i]) begin
      step(tbl[i].dv, tbl[i].d, tbl[i].sub, tbl[i].clr, tbl[i].rl, 0);
      chk($sformatf("t%0d_cnt", i), 32'(digits_cnt), 32'(tbl[i].e_cnt));
      chk($sformatf("t%0d_guess", i), 32'(guess), 32'(tbl[i].e_guess));
      chk($sformatf("t%0d_unlocked", i), 32'(unlocked), 32'(tbl[i].e_unl));
      chk($sformatf("t%0d_locked", i), 32'(locked_out), 32'(tbl[i].e_lck));
      chk($sformatf("t%0d_tries", i), 32'(tries), 32'(tbl[i].e_tries));
      chk($sformatf("t%0d_fbv", i), 32'(fb_valid), 32'(tbl[i].e_fbv));
      chk($sformatf("t%0d_fbc", i), 32'(fb_correct), 32'(tbl[i].e_fbc));
      chk($sformatf("t%0d_fbm", i), 32'(fb_misplaced), 32'(tbl[i].e_fbm));
    end

    // two more misses (tries already 1) reach the lockout
    enter4(1, 0, 2, 3); step(0, 0, 1, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    chk("seq_tries2", 32'(tries), 32'd2);
    enter4(1, 0, 2, 3); step(0, 0, 1, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    chk("seq_lock_enter", 32'(locked_out), 32'd1);
    n_lock = 0;
    for (int i = 0; i < 20 && locked_out; i++) begin
      n_lock++;
      step(1, 2'(i), (i % 2) == 1, 0, 1, 0);
    end
    chk("lock_cycles", 32'(n_lock), 32'(TB_LOCK));
    chk("lock_exit_tries", 32'(tries), 32'd0);
    chk("lock_exit_cnt", 32'(digits_cnt), 32'd0);

    // open, re-key to 3,3,0,0, old code must fail
    enter4(0, 1, 2, 3); step(0, 0, 1, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    chk("open_unlocked", 32'(unlocked), 32'd1);
    step(0, 0, 0, 1, 0, 0);
    enter4(3, 3, 0, 0); step(0, 0, 1, 0, 0, 0);
    chk("rekey_secret", 32'(secret), 32'h0F);
    chk("rekey_unlocked", 32'(unlocked), 32'd0);
    enter4(0, 1, 2, 3); step(0, 0, 1, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
    chk("old_code_unlocked", 32'(unlocked), 32'd0);
    chk("old_code_fbc", 32'(fb_correct), 32'h0);
    chk("old_code_tries", 32'(tries), 32'd1);

    // reset while in EVAL
    enter4(1, 1, 1, 1); step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("evrst_fbv", 32'(fb_valid), 32'd0);
    chk("evrst_secret", 32'(secret), 32'hE4);
    chk("evrst_tries", 32'(tries), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("evrst_fbv_after", 32'(fb_valid), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      if (mq.size() < 4 && $urandom_range(1, 0) == 1) rd = msecret[2*mq.size() +: 2];
      else rd = 2'($urandom_range(3, 0));
      step($urandom_range(1, 0) == 1, rd, $urandom_range(3, 0) == 0,
           $urandom_range(19, 0) == 0, $urandom_range(9, 0) == 0,
           $urandom_range(299, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
